// File: rtl/vrb_pkg.sv
// vrb_pkg -- definitions shared by the two-master vrb arbiter.
//   state_e    : arbiter state (IDLE, BUSY)
//   mst_idx_t  : master index, MST_IFU (instruction fetch) / MST_LSU (load-store)
//   TIMEOUT_DEF: default number of BUSY cycles before an error completion
//   rr_pick    : two-way round-robin winner selection
package vrb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef logic mst_idx_t;

   localparam mst_idx_t MST_IFU = 1'b0;
   localparam mst_idx_t MST_LSU = 1'b1;

   localparam int unsigned TIMEOUT_DEF = 32'd255;

   // A lone requester always wins; on a tie the master that did not win last time goes.
   function automatic mst_idx_t rr_pick(input logic [1:0] req, input mst_idx_t last);
      mst_idx_t win;
      case (req)
         2'b01:   win = MST_IFU;
         2'b10:   win = MST_LSU;
         2'b11:   win = ~last;
         default: win = MST_IFU;
      endcase
      return win;
   endfunction

endpackage

// File: rtl/vrb_rr_arb.sv
// vrb_rr_arb -- purely combinational 2-way round-robin picker.
//   req_i        : request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant_i : master granted most recently
//   winner_o     : selected master (only meaningful when any_o is high)
//   any_o        : at least one request is present
module vrb_rr_arb
   import vrb_pkg::*;
(
   input  logic [1:0] req_i,
   input  mst_idx_t   last_grant_i,
   output mst_idx_t   winner_o,
   output logic       any_o
);

   assign any_o    = |req_i;
   assign winner_o = rr_pick(req_i, last_grant_i);

endmodule

// File: rtl/vrb_arbiter.sv
// vrb_arbiter -- shares one vrb slave port between an instruction-fetch
// master (m0) and a load-store master (m1). One transaction is outstanding
// at a time; ties are broken round-robin.
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_mN_cmd_*           : command from master N (valid/addr/read/wdata/wmask)
//   o_mN_rsp_*           : one-cycle response pulse to master N (valid/err/rdata)
//   o_vrb_cmd_*          : command presented to the shared slave
//   i_vrb_rsp_*          : response from the shared slave
// A transaction that sees no slave response completes with err=1 after
// TIMEOUT BUSY cycles. A granted master that drops its request aborts the
// transaction silently.
module vrb_arbiter
   import vrb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            i_m0_cmd_valid,
   input  logic [AW-1:0]   i_m0_cmd_addr,
   input  logic            i_m0_cmd_read,
   input  logic [DW-1:0]   i_m0_cmd_wdata,
   input  logic [DW/8-1:0] i_m0_cmd_wmask,

   input  logic            i_m1_cmd_valid,
   input  logic [AW-1:0]   i_m1_cmd_addr,
   input  logic            i_m1_cmd_read,
   input  logic [DW-1:0]   i_m1_cmd_wdata,
   input  logic [DW/8-1:0] i_m1_cmd_wmask,

   output logic            o_m0_rsp_valid,
   output logic            o_m0_rsp_err,
   output logic [DW-1:0]   o_m0_rsp_rdata,

   output logic            o_m1_rsp_valid,
   output logic            o_m1_rsp_err,
   output logic [DW-1:0]   o_m1_rsp_rdata,

   output logic            o_vrb_cmd_valid,
   output logic [AW-1:0]   o_vrb_cmd_addr,
   output logic            o_vrb_cmd_read,
   output logic [DW-1:0]   o_vrb_cmd_wdata,
   output logic [DW/8-1:0] o_vrb_cmd_wmask,

   input  logic            i_vrb_rsp_valid,
   input  logic            i_vrb_rsp_err,
   input  logic [DW-1:0]   i_vrb_rsp_rdata
);

   // Counter value on which the transaction is given up.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

   state_e        state_q, state_d;
   mst_idx_t      grant_q, grant_d;
   mst_idx_t      last_grant_q, last_grant_d;
   logic [7:0]    cnt_q, cnt_d;

   mst_idx_t      arb_winner_s;
   logic          arb_any_s;
   logic          g_valid_s;
   logic          expire_s;
   logic          rsp_valid_s;
   logic          rsp_err_s;
   logic [DW-1:0] rsp_rdata_s;

   vrb_rr_arb u_rr_arb (
      .req_i        ({i_m1_cmd_valid, i_m0_cmd_valid}),
      .last_grant_i (last_grant_q),
      .winner_o     (arb_winner_s),
      .any_o        (arb_any_s)
   );

   assign g_valid_s = (grant_q == MST_LSU) ? i_m1_cmd_valid : i_m0_cmd_valid;
   assign expire_s  = (cnt_q == CNT_LAST);

   // State register; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= MST_IFU;
         last_grant_q <= MST_IFU;
         cnt_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic and slave-side command/response selection.
   always_comb begin
      state_d         = state_q;
      grant_d         = grant_q;
      last_grant_d    = last_grant_q;
      cnt_d           = cnt_q;
      o_vrb_cmd_valid = 1'b0;
      o_vrb_cmd_addr  = {AW{1'b0}};
      o_vrb_cmd_read  = 1'b0;
      o_vrb_cmd_wdata = {DW{1'b0}};
      o_vrb_cmd_wmask = {(DW/8){1'b0}};
      rsp_valid_s     = 1'b0;
      rsp_err_s       = 1'b0;
      rsp_rdata_s     = {DW{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (arb_any_s) begin
               state_d      = ST_BUSY;
               grant_d      = arb_winner_s;
               last_grant_d = arb_winner_s;
               cnt_d        = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (grant_q == MST_LSU) begin
               o_vrb_cmd_addr  = i_m1_cmd_addr;
               o_vrb_cmd_read  = i_m1_cmd_read;
               o_vrb_cmd_wdata = i_m1_cmd_wdata;
               o_vrb_cmd_wmask = i_m1_cmd_wmask;
            end else begin
               o_vrb_cmd_addr  = i_m0_cmd_addr;
               o_vrb_cmd_read  = i_m0_cmd_read;
               o_vrb_cmd_wdata = i_m0_cmd_wdata;
               o_vrb_cmd_wmask = i_m0_cmd_wmask;
            end
            // The command is withdrawn from the slave on the expiry cycle.
            o_vrb_cmd_valid = g_valid_s & ~expire_s;
            if (!g_valid_s) begin
               // Master abort: no response to anybody.
               state_d = ST_IDLE;
            end else if (i_vrb_rsp_valid) begin
               // A real slave response beats a simultaneous expiry.
               rsp_valid_s = 1'b1;
               rsp_err_s   = i_vrb_rsp_err;
               rsp_rdata_s = i_vrb_rsp_rdata;
               state_d     = ST_IDLE;
            end else if (expire_s) begin
               rsp_valid_s = 1'b1;
               rsp_err_s   = 1'b1;
               rsp_rdata_s = {DW{1'b0}};
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Steer the completion to the granted master only.
   always_comb begin
      o_m0_rsp_valid = 1'b0;
      o_m0_rsp_err   = 1'b0;
      o_m0_rsp_rdata = {DW{1'b0}};
      o_m1_rsp_valid = 1'b0;
      o_m1_rsp_err   = 1'b0;
      o_m1_rsp_rdata = {DW{1'b0}};
      if (grant_q == MST_LSU) begin
         o_m1_rsp_valid = rsp_valid_s;
         o_m1_rsp_err   = rsp_err_s;
         o_m1_rsp_rdata = rsp_rdata_s;
      end else begin
         o_m0_rsp_valid = rsp_valid_s;
         o_m0_rsp_err   = rsp_err_s;
         o_m0_rsp_rdata = rsp_rdata_s;
      end
   end

endmodule

// File: tb/tb_vrb_arbiter.sv
// tb_vrb_arbiter -- self-checking bench for vrb_arbiter (TIMEOUT=4).
// A transaction-level reference model (who owns the slave, how long it has
// waited) predicts every output each cycle; directed tasks add fixed
// expectations for the documented scenarios.
module tb_vrb_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          m0_v, m0_r, m1_v, m1_r;
   logic [AW-1:0] m0_a, m1_a;
   logic [DW-1:0] m0_w, m1_w;
   logic [MW-1:0] m0_m, m1_m;
   logic          s_v, s_e;
   logic [DW-1:0] s_d;

   logic          r0_v, r0_e, r1_v, r1_e;
   logic [DW-1:0] r0_d, r1_d;
   logic          v_v, v_r;
   logic [AW-1:0] v_a;
   logic [DW-1:0] v_w;
   logic [MW-1:0] v_m;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: is a transaction in flight, whose, how long it waited.
   bit mdl_busy;
   int mdl_owner;
   int mdl_last;
   int mdl_age;

   vrb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_m0_cmd_valid  (m0_v),
      .i_m0_cmd_addr   (m0_a),
      .i_m0_cmd_read   (m0_r),
      .i_m0_cmd_wdata  (m0_w),
      .i_m0_cmd_wmask  (m0_m),
      .i_m1_cmd_valid  (m1_v),
      .i_m1_cmd_addr   (m1_a),
      .i_m1_cmd_read   (m1_r),
      .i_m1_cmd_wdata  (m1_w),
      .i_m1_cmd_wmask  (m1_m),
      .o_m0_rsp_valid  (r0_v),
      .o_m0_rsp_err    (r0_e),
      .o_m0_rsp_rdata  (r0_d),
      .o_m1_rsp_valid  (r1_v),
      .o_m1_rsp_err    (r1_e),
      .o_m1_rsp_rdata  (r1_d),
      .o_vrb_cmd_valid (v_v),
      .o_vrb_cmd_addr  (v_a),
      .o_vrb_cmd_read  (v_r),
      .o_vrb_cmd_wdata (v_w),
      .o_vrb_cmd_wmask (v_m),
      .i_vrb_rsp_valid (s_v),
      .i_vrb_rsp_err   (s_e),
      .i_vrb_rsp_rdata (s_d)
   );

   always #5 clk = ~clk;

   function automatic logic [137:0] dut_bus();
      return {r0_v, r0_e, r0_d, r1_v, r1_e, r1_d, v_v, v_a, v_r, v_w, v_m};
   endfunction

   // Expected outputs for the current cycle from model state and current inputs.
   function automatic logic [137:0] model_bus();
      logic          ov, expiring, rv, re, vv, r;
      logic [DW-1:0] rd, w;
      logic [AW-1:0] a;
      logic [MW-1:0] m;
      logic [33:0]   rsp0, rsp1;
      rsp0 = '0; rsp1 = '0; vv = 1'b0; a = '0; r = 1'b0; w = '0; m = '0;
      if (mdl_busy) begin
         ov       = (mdl_owner == 1) ? m1_v : m0_v;
         expiring = (mdl_age == TO - 1);
         if (mdl_owner == 1) {a, r, w, m} = {m1_a, m1_r, m1_w, m1_m};
         else                {a, r, w, m} = {m0_a, m0_r, m0_w, m0_m};
         vv = ov && !expiring;
         rv = 1'b0; re = 1'b0; rd = '0;
         if (ov && s_v) begin
            rv = 1'b1; re = s_e; rd = s_d;
         end else if (ov && expiring) begin
            rv = 1'b1; re = 1'b1; rd = '0;
         end
         if (mdl_owner == 1) rsp1 = {rv, re, rd};
         else                rsp0 = {rv, re, rd};
      end
      return {rsp0, rsp1, vv, a, r, w, m};
   endfunction

   function automatic void mdl_reset();
      mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 0; mdl_age = 0;
   endfunction

   // Model update at a rising edge.
   function automatic void mdl_edge();
      logic ov;
      if (mdl_busy) begin
         ov = (mdl_owner == 1) ? m1_v : m0_v;
         if (!ov || s_v || (mdl_age == TO - 1)) mdl_busy = 1'b0;
         else                                   mdl_age  = mdl_age + 1;
      end else if (m0_v || m1_v) begin
         if (m0_v && m1_v) mdl_owner = 1 - mdl_last;
         else              mdl_owner = m1_v ? 1 : 0;
         mdl_last = mdl_owner;
         mdl_busy = 1'b1;
         mdl_age  = 0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) mdl_reset();
      else        mdl_edge();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m0_v = 1'b0; m0_a = '0; m0_r = 1'b0; m0_w = '0; m0_m = '0;
      m1_v = 1'b0; m1_a = '0; m1_r = 1'b0; m1_w = '0; m1_m = '0;
      s_v = 1'b0; s_e = 1'b0; s_d = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      mdl_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      mdl_reset();
      #1;
      if (dut_bus() !== 138'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h want 0", dut_bus());
      end
      n_vec++;
      // Requests while reset is held must not be granted.
      m0_v = 1'b1; m1_v = 1'b1;
      #10;
      if (dut_bus() !== 138'd0) begin
         n_err++; $display("FAIL reset_hold: got %h want 0", dut_bus());
      end
      n_vec++;
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      #1;
      if (dut_bus() !== model_bus()) begin
         n_err++; $display("FAIL reset_release: got %h want %h", dut_bus(), model_bus());
      end
      n_vec++;
      tick();
   endtask

   task automatic test_store();
      clear_inputs();
      m1_v = 1'b1; m1_a = 32'h0000_0100; m1_r = 1'b0; m1_w = 32'hDEAD_BEEF; m1_m = 4'hF;
      m0_a = $urandom; m0_w = $urandom;
      for (int c = 0; c < 5; c++) begin
         s_v = (c == 3); s_e = 1'b0; s_d = 32'h0BAD_F00D;
         #1;
         if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL store_model c%0d: got %h want %h", c, dut_bus(), model_bus());
         end
         n_vec++;
         if (c >= 1 && c <= 3) begin
            if ({v_v, v_a, v_r, v_w, v_m} !== {1'b1, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 4'hF}) begin
               n_err++; $display("FAIL store_fields c%0d: got %b %h %b %h %h", c, v_v, v_a, v_r, v_w, v_m);
            end
            n_vec++;
         end
         if ({r1_v, r0_v} !== ((c == 3) ? 2'b10 : 2'b00)) begin
            n_err++; $display("FAIL store_rsp c%0d: got %b want %b", c, {r1_v, r0_v}, (c == 3) ? 2'b10 : 2'b00);
         end
         n_vec++;
         tick();
         if (c == 3) m1_v = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_dual_rr();
      do_reset();
      m0_v = 1'b1; m0_a = 32'h0000_1000; m0_r = 1'b1;
      m1_v = 1'b1; m1_a = 32'h0000_2000; m1_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s_v = 1'b0;
         #1;
         if (dut_bus() !== model_bus() || v_v !== 1'b0) begin
            n_err++; $display("FAIL rr_idle k%0d: got %h want %h", k, dut_bus(), model_bus());
         end
         n_vec++;
         tick();
         s_v = 1'b1; s_e = 1'b0; s_d = $urandom;
         #1;
         if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL rr_model k%0d: got %h want %h", k, dut_bus(), model_bus());
         end
         n_vec++;
         if ({v_a, r1_v, r0_v} !== ((k % 2 == 0) ? {32'h0000_2000, 2'b10} : {32'h0000_1000, 2'b01})) begin
            n_err++; $display("FAIL rr_order k%0d: got addr %h rsp %b", k, v_a, {r1_v, r0_v});
         end
         n_vec++;
         tick();
         // Winner immediately issues its next transaction.
         if (k % 2 == 0) m1_w = $urandom;
         else            m0_w = $urandom;
      end
      clear_inputs();
   endtask

   task automatic test_zero_latency();
      clear_inputs();
      m0_v = 1'b1; m0_r = 1'b1; m0_a = $urandom;
      m1_a = 32'h0000_0040; m1_r = 1'b1;
      for (int c = 0; c < 4; c++) begin
         s_v = (c == 1 || c == 3); s_e = 1'b0; s_d = 32'h1234_5678;
         if (c == 1) m1_v = 1'b1;
         #1;
         if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL zl_model c%0d: got %h want %h", c, dut_bus(), model_bus());
         end
         n_vec++;
         if (c == 1 && {r0_v, r0_e, r0_d, v_v} !== {1'b1, 1'b0, 32'h1234_5678, 1'b1}) begin
            n_err++; $display("FAIL zl_rsp: got %b %b %h %b", r0_v, r0_e, r0_d, v_v);
         end
         if (c == 2 && {r0_v, r1_v, v_v} !== 3'b000) begin
            n_err++; $display("FAIL zl_gap: got %b want 000", {r0_v, r1_v, v_v});
         end
         if (c == 3 && {v_v, v_a} !== {1'b1, 32'h0000_0040}) begin
            n_err++; $display("FAIL zl_next: got %b %h", v_v, v_a);
         end
         if (c != 0) n_vec++;
         tick();
         if (c == 1) m0_v = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      clear_inputs();
      m0_v = 1'b1; m0_r = 1'b1; m0_a = $urandom;
      for (int c = 0; c < 6; c++) begin
         s_v = (c == 5); s_e = 1'b0; s_d = 32'hCAFE_0001;
         #1;
         if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL to_model c%0d: got %h want %h", c, dut_bus(), model_bus());
         end
         n_vec++;
         if ({v_v, r0_v, r0_e, r0_d, r1_v} !==
             {(c >= 1 && c <= 3), ((c == 4) ? {1'b1, 1'b1, 32'h0} : 34'h0), 1'b0}) begin
            n_err++; $display("FAIL to_seq c%0d: got v%b r%b e%b d%h", c, v_v, r0_v, r0_e, r0_d);
         end
         n_vec++;
         tick();
         if (c == 4) m0_v = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_abort();
      clear_inputs();
      m1_v = 1'b1; m1_r = 1'b1; m1_a = $urandom;
      for (int c = 0; c < 4; c++) begin
         s_v = (c == 3); s_d = 32'h5555_AAAA;
         #1;
         if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL abort_model c%0d: got %h want %h", c, dut_bus(), model_bus());
         end
         n_vec++;
         if ({v_v, r0_v, r1_v} !== {(c == 1), 2'b00}) begin
            n_err++; $display("FAIL abort_seq c%0d: got %b", c, {v_v, r0_v, r1_v});
         end
         n_vec++;
         tick();
         if (c == 1) m1_v = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_busy();
      clear_inputs();
      m1_v = 1'b1; m1_r = 1'b0; m1_a = $urandom; m1_w = $urandom; m1_m = 4'h3;
      tick();
      #1;
      if (v_v !== 1'b1 || dut_bus() !== model_bus()) begin
         n_err++; $display("FAIL rstb_busy: got %h want %h", dut_bus(), model_bus());
      end
      n_vec++;
      rst_n = 1'b0; s_v = 1'b1; s_d = $urandom;
      mdl_reset();
      #1;
      if (dut_bus() !== 138'd0) begin
         n_err++; $display("FAIL rstb_async: got %h want 0", dut_bus());
      end
      n_vec++;
      tick();
      rst_n = 1'b1;
      clear_inputs();
      m0_v = 1'b1; m0_r = 1'b1; m0_a = 32'h0000_0ABC;
      #1;
      if (dut_bus() !== 138'd0) begin
         n_err++; $display("FAIL rstb_idle: got %h want 0", dut_bus());
      end
      n_vec++;
      tick();
      s_v = 1'b1; s_d = 32'h0F0F_0F0F;
      #1;
      if ({v_v, v_a, r0_v, r0_d, r1_v} !== {1'b1, 32'h0000_0ABC, 1'b1, 32'h0F0F_0F0F, 1'b0}
          || dut_bus() !== model_bus()) begin
         n_err++; $display("FAIL rstb_after: got %h want %h", dut_bus(), model_bus());
      end
      n_vec++;
      tick();
      clear_inputs();
   endtask

   task automatic test_random(input int cycles);
      logic [137:0] exp_v;
      clear_inputs();
      for (int i = 0; i < cycles; i++) begin
         if (!m0_v && $urandom_range(0, 2) == 0) begin
            m0_v = 1'b1; m0_a = $urandom; m0_r = 1'($urandom); m0_w = $urandom; m0_m = 4'($urandom);
         end else if (m0_v && $urandom_range(0, 19) == 0) begin
            m0_v = 1'b0;
         end
         if (!m1_v && $urandom_range(0, 2) == 0) begin
            m1_v = 1'b1; m1_a = $urandom; m1_r = 1'($urandom); m1_w = $urandom; m1_m = 4'($urandom);
         end else if (m1_v && $urandom_range(0, 19) == 0) begin
            m1_v = 1'b0;
         end
         s_v = ($urandom_range(0, 3) == 0); s_e = 1'($urandom); s_d = $urandom;
         #1;
         exp_v = model_bus();
         if (dut_bus() !== exp_v) begin
            n_err++; $display("FAIL random i%0d: got %h want %h", i, dut_bus(), exp_v);
         end
         n_vec++;
         tick();
         if (exp_v[137]) m0_v = 1'b0;
         if (exp_v[103]) m1_v = 1'b0;
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_store();
      test_dual_rr();
      test_zero_latency();
      test_timeout();
      test_abort();
      test_reset_mid_busy();
      test_random(400);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vrb_arbiter.md
VRB_ARBITER -- requirements
Module: vrb_arbiter

Interface
REQ-001 AW, 32, address width.
REQ-002 DW, 32, data width.
REQ-003 TIMEOUT, 255, BUSY cycles without slave response before error completion; legal 2..255.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 i_mN_cmd_valid  input  1  request from master N (N=0 instruction fetch, N=1 LSU).
REQ-007 i_mN_cmd_addr / i_mN_cmd_read / i_mN_cmd_wdata / i_mN_cmd_wmask  input  AW/1/DW/DW/8  master N command fields.
REQ-008 o_mN_rsp_valid / o_mN_rsp_err / o_mN_rsp_rdata  output  1/1/DW  response to master N.
REQ-009 o_vrb_cmd_valid / o_vrb_cmd_addr / o_vrb_cmd_read / o_vrb_cmd_wdata / o_vrb_cmd_wmask  output  1/AW/1/DW/DW/8  command to shared vrb slave.
REQ-010 i_vrb_rsp_valid / i_vrb_rsp_err / i_vrb_rsp_rdata  input  1/1/DW  slave response.

Function
REQ-011 Protocol: master holds cmd_valid and fields stable until its rsp_valid; rsp_valid pulses one cycle per transaction; one outstanding transaction total.
REQ-012 States: IDLE, BUSY; register grant (1 bit), last_grant (1 bit), timeout counter (8 bits).
REQ-013 IDLE: if any i_mN_cmd_valid, latch winner into grant, go BUSY next cycle; else stay IDLE; all o_vrb_cmd_* and o_mN_rsp_* are 0 in IDLE.
REQ-014 Arbitration: single requester wins; both requesting -> master != last_grant wins (round-robin); last_grant updated on every IDLE->BUSY.
REQ-015 BUSY: o_vrb_cmd_* = granted master's fields combinationally, o_vrb_cmd_valid = granted i_mN_cmd_valid; non-granted master sees rsp_valid=0.
REQ-016 BUSY with i_vrb_rsp_valid: same cycle o_mG_rsp_valid=1, err/rdata passed through, other master rsp all 0; next state IDLE.
REQ-017 Arbitration latency: request in IDLE cycle T -> o_vrb_cmd_valid at T+1; earliest completion T+1; next grant earliest at T+2 (one idle cycle between transactions).
REQ-018 Counter cleared on IDLE->BUSY, increments each BUSY cycle without i_vrb_rsp_valid; on reaching TIMEOUT-1: o_vrb_cmd_valid=0, o_mG_rsp_valid=1, o_mG_rsp_err=1, rdata=0, next IDLE.
REQ-019 Response and timeout in same cycle: slave response wins, err = i_vrb_rsp_err.
REQ-020 Granted master drops cmd_valid in BUSY (abort): o_vrb_cmd_valid=0 that cycle, no master response, next IDLE; i_vrb_rsp_valid arriving in IDLE is ignored.
REQ-021 i_vrb_rsp_err with DW-wide rdata forwarded unchanged; arbiter never alters addr/wdata/wmask.

Reset
REQ-022 rst_n low: state=IDLE, grant=0, last_grant=0 (LSU wins first tie), counter=0, all outputs 0 immediately (asynchronous).
REQ-023 Reset mid-BUSY: transaction dropped, no response issued; after release, first arbitration occurs on first rising edge with rst_n high.

Structure
REQ-024 Shared package vrb_pkg: state enum (IDLE, BUSY), master index typedef, master encodings (IFU=0, LSU=1), TIMEOUT default.
REQ-025 One sub-module vrb_rr_arb: 2-way combinational round-robin picker (req[1:0], last_grant -> winner, any).

Verification
REQ-026 Only m1 store addr 0x100, wdata 0xDEADBEEF, wmask 0xF; slave responds 2 cycles after o_vrb_cmd_valid -> slave sees exact fields, o_m1_rsp_valid one cycle, m0 rsp stays 0.
REQ-027 m0 and m1 request same cycle after reset -> m1 granted first, then m0; repeated dual requests alternate m0/m1.
REQ-028 m0 load, slave responds same cycle o_vrb_cmd_valid rises with rdata 0x12345678 -> o_m0_rsp_valid same cycle, rdata 0x12345678, IDLE next cycle.
REQ-029 TIMEOUT=4, slave silent -> o_vrb_cmd_valid high 3 cycles, then rsp_valid=1, err=1, rdata=0 to granted master; late slave response ignored.
REQ-030 rst_n asserted during BUSY with m1 granted -> outputs 0 without clock edge; after release m0 request granted normally.
